uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver, 8N1 by default, mid-bit sampling, LSB first.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, also used by the planned uart_tx.
// No logic here, so there is no latency and no backpressure.
package uart_pkg;

   localparam int DEF_CLKS_PER_BIT = 868;
   localparam int DEF_DATA_BITS    = 8;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t START = 3'd1;
   localparam state_t DATA  = 3'd2;
   localparam state_t STOP  = 3'd3;
   localparam state_t BRK   = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; reset value is a parameter.
// Latency is 2 clk; there is no backpressure.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; valid comes 1 clk after the stop-bit sample.
// There is no backpressure: a byte that the consumer misses is lost.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   logic                 rx_s;
   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt, err_nxt;

   // Idle-high reset value keeps the line from looking like a start bit.
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = idx;
      shreg_nxt = shreg;
      data_nxt  = data;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_FULL) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rx_s;
               idx_nxt        = idx + IW'(1);
               if (idx == IDX_LAST) state_nxt = STOP;
            end
         end
         STOP: begin
            if (cnt == CNT_FULL) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = BRK;
               end
            end
         end
         BRK: begin
            // Line held low (break): wait for it to return idle before rearming.
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= err_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (4 clk/bit) and a 868 clk/bit instance.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_f, rx_l;
   logic [7:0] data_f, data_l;
   logic       valid_f, valid_l, err_f, err_l, busy_f, busy_l;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx_f),
      .data      (data_f),
      .valid     (valid_f),
      .frame_err (err_f),
      .busy      (busy_f)
   );

   uart_rx #(.CLKS_PER_BIT(868), .DATA_BITS(8)) dut_slow (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx_l),
      .data      (data_l),
      .valid     (valid_l),
      .frame_err (err_l),
      .busy      (busy_l)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] dat;
   } evt_t;

   evt_t q_f[$];
   evt_t q_l[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame LSB first: start bit, 8 data bits, stop bit, each per clk long.
   task automatic send(input bit slow, input logic [7:0] b, input logic stop_bit, input int per);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (slow) rx_l = fr[i];
         else      rx_f = fr[i];
         tick(per);
      end
   endtask

   always @(negedge clk) begin
      if (valid_f || err_f) begin
         check("fast_excl", 32'(valid_f & err_f), 32'd0);
         if (q_f.size() == 0) begin
            n_chk++;
            $display("FAIL fast_spurious: got err=%0b data=%0h, expected no event", err_f, data_f);
         end else begin
            check("fast_evt", 32'({err_f, data_f}), 32'(q_f[0]));
            void'(q_f.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (valid_l || err_l) begin
         check("slow_excl", 32'(valid_l & err_l), 32'd0);
         if (q_l.size() == 0) begin
            n_chk++;
            $display("FAIL slow_spurious: got err=%0b data=%0h, expected no event", err_l, data_l);
         end else begin
            check("slow_evt", 32'({err_l, data_l}), 32'(q_l[0]));
            void'(q_l.pop_front());
         end
      end
   end

   initial begin
      logic [9:0] fr55;
      rst_n = 1'b0;
      rx_f  = 1'b1;
      rx_l  = 1'b1;
      tick(3);
      check("rst_data",  32'(data_f),  32'h0);
      check("rst_valid", 32'(valid_f), 32'h0);
      check("rst_err",   32'(err_f),   32'h0);
      check("rst_busy",  32'(busy_f),  32'h0);
      rst_n = 1'b1;
      tick(3);

      // 1: single good frame
      q_f.push_back('{1'b0, 8'hA5});
      send(0, 8'hA5, 1'b1, 4);
      tick(3);
      check("t1_busy_after", 32'(busy_f), 32'h0);

      // 2: back-to-back with no idle gap
      q_f.push_back('{1'b0, 8'h00});
      q_f.push_back('{1'b0, 8'hFF});
      send(0, 8'h00, 1'b1, 4);
      send(0, 8'hFF, 1'b1, 4);
      tick(3);

      // 3: one-clock glitch while idle
      rx_f = 1'b0;
      tick(1);
      rx_f = 1'b1;
      tick(8);
      check("t3_busy_after", 32'(busy_f), 32'h0);

      // 4: stop bit low, line held low, then released; data must keep 0xFF
      q_f.push_back('{1'b1, 8'hFF});
      send(0, 8'h3C, 1'b0, 4);
      tick(20);
      check("t4_busy_brk", 32'(busy_f), 32'h1);
      rx_f = 1'b1;
      tick(4);
      check("t4_busy_after", 32'(busy_f), 32'h0);

      // 5: reset in the middle of bit 4 of 0x55, then a clean 0x81
      fr55 = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_f = fr55[i];
         tick(4);
      end
      rx_f = fr55[5];
      tick(2);
      rst_n = 1'b0;
      #1;
      check("t5_rst_data",  32'(data_f),  32'h0);
      check("t5_rst_valid", 32'(valid_f), 32'h0);
      check("t5_rst_err",   32'(err_f),   32'h0);
      check("t5_rst_busy",  32'(busy_f),  32'h0);
      rx_f = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      q_f.push_back('{1'b0, 8'h81});
      send(0, 8'h81, 1'b1, 4);
      tick(4);
      check("t5_data_after", 32'(data_f), 32'h81);

      // 6: 868 clk/bit receiver, sender 2% slow then 2% fast
      q_l.push_back('{1'b0, 8'h5A});
      send(1, 8'h5A, 1'b1, 885);
      tick(868 * 2);
      q_l.push_back('{1'b0, 8'h5A});
      send(1, 8'h5A, 1'b1, 851);
      tick(868 * 2);
      check("t6_data_after", 32'(data_l), 32'h5A);

      check("fast_pending", 32'(q_f.size()), 32'd0);
      check("slow_pending", 32'(q_l.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
